// File: rtl/clock_sequencer_pkg.sv
// Shared encodings, widths and helpers for the clock_controller bring-up sequencer.
package clock_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Counter width sized to the largest timing parameter, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clock_sequencer_if.sv
// Control/status bundle between the sequencer and the clock_controller/system side.
interface clock_sequencer_if;
  import clock_sequencer_pkg::*;

  logic               locked;
  logic               restart;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               failed;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  loss_cnt;
  logic [STATE_W-1:0] state;

  modport master (
    input  locked, restart,
    output pll_rst, sys_rst, ready, failed, retry_cnt, loss_cnt, state
  );

  modport slave (
    output locked, restart,
    input  pll_rst, sys_rst, ready, failed, retry_cnt, loss_cnt, state
  );

endinterface

// File: rtl/clock_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, clears to 0 on reset.
module clock_sequencer_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_sequencer.sv
// Bring-up and supervision FSM for clock_controller: reset pulse, lock wait,
// settle qualification, run supervision with retry/loss accounting.
module clock_sequencer
  import clock_sequencer_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 33,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 33000,
  parameter int unsigned SETTLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic              clk_33,
  input  logic              rst,
  clock_sequencer_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_e             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [RETRY_W-1:0] retry_q, retry_nx;
  logic [LOSS_W-1:0]  loss_q, loss_nx;
  logic               attempt_fail;
  logic               pll_rst_q, pll_rst_nx;
  logic               sys_rst_q, sys_rst_nx;
  logic               ready_q, ready_nx;
  logic               failed_q, failed_nx;

  clock_sequencer_sync_2ff u_lock_sync (
    .clk (clk_33),
    .rst (rst),
    .d   (bus.locked),
    .q   (lock_s)
  );

  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q + CNT_W'(1);
    retry_nx     = retry_q;
    loss_nx      = loss_q;
    attempt_fail = 1'b0;

    case (state_q)
      ST_RESET:     if (cnt_q == RST_LAST) state_nx = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)                  state_nx     = ST_SETTLE;
        else if (cnt_q == TMO_LAST)  attempt_fail = 1'b1;
      end
      ST_SETTLE: begin
        if (!lock_s)                 attempt_fail = 1'b1;
        else if (cnt_q == SETTLE_LAST) state_nx   = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nx = ST_RESET;
          if (loss_q != '1) loss_nx = loss_q + LOSS_W'(1);
        end
      end
      ST_FAIL:      state_nx = ST_FAIL;
      default:      state_nx = ST_RESET;
    endcase

    if (attempt_fail) begin
      if ((MAX_RETRIES != 0) && (retry_q == RETRY_LIM)) begin
        state_nx = ST_FAIL;
      end else begin
        state_nx = ST_RESET;
        if (retry_q != '1) retry_nx = retry_q + RETRY_W'(1);
      end
    end

    if (state_nx == ST_RUN) retry_nx = '0;

    // restart outranks every lock-driven event, but lock-loss history survives it
    if (bus.restart) begin
      state_nx = ST_RESET;
      retry_nx = '0;
      loss_nx  = loss_q;
    end

    if ((state_nx != state_q) || bus.restart) cnt_nx = '0;

    pll_rst_nx = (state_nx == ST_RESET) || (state_nx == ST_FAIL);
    sys_rst_nx = (state_nx != ST_RUN);
    ready_nx   = (state_nx == ST_RUN);
    failed_nx  = (state_nx == ST_FAIL);
  end

  always_ff @(posedge clk_33) begin
    if (rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      retry_q   <= retry_nx;
      loss_q    <= loss_nx;
      pll_rst_q <= pll_rst_nx;
      sys_rst_q <= sys_rst_nx;
      ready_q   <= ready_nx;
      failed_q  <= failed_nx;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.failed    = failed_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed scoreboard bench for clock_sequencer with short timing parameters.
module tb_clock_sequencer;

  localparam int S_RESET = 0;
  localparam int S_WAIT  = 1;
  localparam int S_SETL  = 2;
  localparam int S_RUN   = 3;
  localparam int S_FAIL  = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  clock_sequencer_if bus ();

  clock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .SETTLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk_33 (clk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    string tag;
    int    st, pll, sys, rdy, fl, rc, lc;
  } snap_t;

  snap_t sb[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_snap(input string tag, input int st, input int pll, input int sys,
                             input int rdy, input int fl, input int rc, input int lc);
    snap_t e;
    e.tag = tag; e.st = st; e.pll = pll; e.sys = sys; e.rdy = rdy;
    e.fl = fl; e.rc = rc; e.lc = lc;
    sb.push_back(e);
  endtask

  task automatic compare_snap();
    snap_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".state"},   int'(bus.state),     e.st);
      chk({e.tag, ".pll_rst"}, int'(bus.pll_rst),   e.pll);
      chk({e.tag, ".sys_rst"}, int'(bus.sys_rst),   e.sys);
      chk({e.tag, ".ready"},   int'(bus.ready),     e.rdy);
      chk({e.tag, ".failed"},  int'(bus.failed),    e.fl);
      chk({e.tag, ".retry"},   int'(bus.retry_cnt), e.rc);
      chk({e.tag, ".loss"},    int'(bus.loss_cnt),  e.lc);
    end
  endtask

  // Tick until state matches target; n returns the number of edges taken.
  task automatic wait_state(input string tag, input int target, input int budget, output int n);
    n = 0;
    while ((int'(bus.state) != target) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk({tag, ".reach"}, int'(bus.state), target);
  endtask

  task automatic lose_lock();
    int n;
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    wait_state("loss_reset", S_RESET, 5, n);
    wait_state("loss_rerun", S_RUN, 40, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst         = 1'b1;
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    tick(3);
    expect_snap("reset", S_RESET, 1, 1, 0, 0, 0, 0);
    compare_snap();
    rst = 1'b0;

    // clean bring-up
    wait_state("pulse", S_WAIT, 10, n);
    chk("pulse_len", n, 4);
    chk("pulse_pll_low", int'(bus.pll_rst), 0);
    tick(10);
    chk("wait_hold", int'(bus.state), S_WAIT);
    bus.locked = 1'b1;
    wait_state("to_settle", S_SETL, 10, n);
    chk("sync_latency", n, 3);
    expect_snap("run1", S_RUN, 0, 0, 1, 0, 0, 0);
    wait_state("to_run", S_RUN, 20, n);
    chk("settle_len", n, 8);
    compare_snap();

    // single-cycle lock loss in RUN
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    tick(1);
    chk("loss_still_run", int'(bus.state), S_RUN);
    expect_snap("loss1", S_RESET, 1, 1, 0, 0, 0, 1);
    tick(1);
    compare_snap();
    wait_state("rerun1", S_RUN, 40, n);
    chk("rerun1_loss", int'(bus.loss_cnt), 1);
    for (int i = 0; i < 299; i++) lose_lock();
    chk("loss_sat", int'(bus.loss_cnt), 255);

    // glitchy lock during SETTLE
    bus.locked = 1'b0;
    wait_state("g_reset", S_RESET, 5, n);
    wait_state("g_wait", S_WAIT, 10, n);
    bus.locked = 1'b1;
    tick(4);
    chk("g_in_settle", int'(bus.state), S_SETL);
    tick(1);
    bus.locked = 1'b0;
    expect_snap("glitch", S_RESET, 1, 1, 0, 0, 1, 255);
    wait_state("g_fail", S_RESET, 10, n);
    compare_snap();
    bus.locked = 1'b1;
    expect_snap("retry_clean", S_RUN, 0, 0, 1, 0, 0, 255);
    wait_state("g_rerun", S_RUN, 40, n);
    compare_snap();

    // lock never arrives: two retries then FAIL
    bus.locked = 1'b0;
    wait_state("t_reset", S_RESET, 5, n);
    wait_state("t_wait1", S_WAIT, 10, n);
    expect_snap("try1", S_RESET, 1, 1, 0, 0, 1, 255);
    wait_state("t_fail1", S_RESET, 25, n);
    chk("timeout_len", n, 20);
    compare_snap();
    wait_state("t_wait2", S_WAIT, 10, n);
    expect_snap("try2", S_RESET, 1, 1, 0, 0, 2, 255);
    wait_state("t_fail2", S_RESET, 25, n);
    compare_snap();
    wait_state("t_wait3", S_WAIT, 10, n);
    expect_snap("fail", S_FAIL, 1, 1, 0, 1, 2, 255);
    wait_state("t_fail3", S_FAIL, 25, n);
    chk("timeout_len3", n, 20);
    compare_snap();
    tick(100);
    expect_snap("fail_hold", S_FAIL, 1, 1, 0, 1, 2, 255);
    compare_snap();

    // restart out of FAIL
    bus.restart = 1'b1;
    expect_snap("restart_fail", S_RESET, 1, 1, 0, 0, 0, 255);
    tick(1);
    bus.restart = 1'b0;
    compare_snap();
    wait_state("rs_pulse", S_WAIT, 10, n);
    chk("restart_pulse_len", n, 4);

    // restart mid-SETTLE
    bus.locked = 1'b1;
    wait_state("rs_settle", S_SETL, 10, n);
    tick(3);
    bus.restart = 1'b1;
    expect_snap("restart_settle", S_RESET, 1, 1, 0, 0, 0, 255);
    tick(1);
    bus.restart = 1'b0;
    bus.locked  = 1'b0;
    compare_snap();
    wait_state("rs_wait", S_WAIT, 10, n);
    chk("restart_pulse_len2", n, 4);

    // restart coincident with the timeout cycle
    tick(19);
    chk("pre_timeout", int'(bus.state), S_WAIT);
    bus.restart = 1'b1;
    expect_snap("restart_tmo", S_RESET, 1, 1, 0, 0, 0, 255);
    tick(1);
    bus.restart = 1'b0;
    compare_snap();
    wait_state("rt_wait", S_WAIT, 10, n);
    chk("restart_pulse_len3", n, 4);

    // synchronous reset mid-WAIT_LOCK with loss_cnt=3
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.locked = 1'b1;
    wait_state("r_run", S_RUN, 40, n);
    lose_lock();
    lose_lock();
    bus.locked = 1'b0;
    wait_state("r_reset", S_RESET, 5, n);
    wait_state("r_wait", S_WAIT, 10, n);
    tick(5);
    chk("r_wait_hold", int'(bus.state), S_WAIT);
    chk("r_loss3", int'(bus.loss_cnt), 3);
    rst = 1'b1;
    expect_snap("rst_mid", S_RESET, 1, 1, 0, 0, 0, 0);
    tick(1);
    compare_snap();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
